// File: rtl/enmixcol_serial_if.sv
// Handshake bundle between the ShiftRows stage, the MixColumns stage and AddRoundKey.
// master drives the state in and takes the result; slave is the MixColumns stage.
interface enmixcol_serial_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] sr;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] mc;

  modport master (
    output in_valid, sr, last_round, out_ready,
    input  in_ready, out_valid, mc
  );

  modport slave (
    input  in_valid, sr, last_round, out_ready,
    output in_ready, out_valid, mc
  );
endinterface

// File: rtl/enmixcol_serial.sv
// AES encryptor MixColumns stage, COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// The accept edge performs the first column group, so a result is ready 4/COLS_PER_CYCLE edges after accept.
module enmixcol_serial #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  enmixcol_serial_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE % 4);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("enmixcol_serial: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] mc_q, mc_d;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Transforms columns first..first+COLS_PER_CYCLE-1; column c sits at s[127-32c -: 32].
  function automatic logic [127:0] mix_group(input logic [127:0] s, input logic [1:0] first);
    logic [127:0] r;
    int           col;
    r = s;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col = int'(first) + k;
      r[127 - 32*col -: 32] = mix_col(s[127 - 32*col -: 32]);
    end
    return r;
  endfunction

  assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.mc        = mc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_d    = mc_q;
    accept  = bus.in_valid & bus.in_ready;

    case (state_q)
      BUSY: begin
        mc_d  = mix_group(mc_q, cnt_q);
        cnt_d = cnt_q + CNT_STEP;
        if (int'(cnt_q) + COLS_PER_CYCLE >= 4) begin
          state_d = DONE;
        end
      end
      default: begin
        if (accept) begin
          if (bus.last_round) begin
            mc_d    = bus.sr;
            cnt_d   = 2'd0;
            state_d = DONE;
          end else begin
            // Column group 0 is done on the accept edge itself.
            mc_d    = mix_group(bus.sr, 2'd0);
            cnt_d   = CNT_STEP;
            state_d = (COLS_PER_CYCLE == 4) ? DONE : BUSY;
          end
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      mc_q    <= 128'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_q    <= mc_d;
    end
  end

endmodule
